// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, BURST} fetch_state_t;

  localparam logic [1:0] SIZE_1  = 2'b00;
  localparam logic [1:0] SIZE_4  = 2'b01;
  localparam logic [1:0] SIZE_8  = 2'b10;
  localparam logic [1:0] SIZE_16 = 2'b11;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h8002_0000;

  localparam int WORD_BYTES = 4;
  localparam int ALIGN_BITS = 2;

  function automatic int burst_words(input logic [1:0] code);
    case (code)
      SIZE_1:  return 1;
      SIZE_4:  return 4;
      SIZE_8:  return 8;
      default: return 16;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit_insn_fifo.sv
// Instruction FIFO of {pc, insn}; the head lives in an output register that
// is refilled from storage (or bypassed from push) so back-to-back pops never bubble.
module insn_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      stor_count;
  logic             load, take, bypass, write;

  always_comb begin
    load   = !head_valid || pop;
    take   = load && (stor_count != '0);
    bypass = load && (stor_count == '0) && push;
    write  = push && !bypass;
  end

  assign count = stor_count + {{PW{1'b0}}, head_valid};

  always_ff @(posedge clock) begin
    if (write) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      stor_count <= '0;
      head_valid <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + 1'b1;
      if (take)  rd_ptr <= rd_ptr + 1'b1;
      stor_count <= stor_count + {{PW{1'b0}}, write} - {{PW{1'b0}}, take};
      if (load) head_valid <= take || bypass;
    end
  end

  // Flush only drops validity; the last instruction stays visible on the output.
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
    end else if (!flush) begin
      if (take)        head <= mem[rd_ptr];
      else if (bypass) head <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues read bursts to main memory and queues the
// returned words for decode. Optional counters are built when FETCH_STATS_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = ADDR_WIDTH'(PC_RESET_DEFAULT),
  parameter logic [1:0]            BURST_CODE = SIZE_4,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [1:0]            mem_access_size,
  output logic                  mem_rw,
  output logic                  mem_enable,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  output logic                  insn_valid,
  input  logic                  insn_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stalls
`endif
);
  localparam int N  = burst_words(BURST_CODE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  if (FIFO_DEPTH < N || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_unit: FIFO_DEPTH must be a power of two holding a full burst");
  end

  fetch_state_t          state, state_nx;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nx, redirect_aligned, word_pc;
  logic [3:0]            word_cnt, word_cnt_nx;
  logic                  discard, discard_nx, push, pop;
  logic [CW-1:0]         count;
  logic [EW-1:0]         head;

  assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(WORD_BYTES - 1);
  assign word_pc          = fetch_pc + (ADDR_WIDTH'(word_cnt) << ALIGN_BITS);
  assign pop              = insn_valid & insn_ready;
  assign mem_address      = fetch_pc;
  assign mem_access_size  = BURST_CODE;
  assign mem_rw           = 1'b0;
  assign mem_enable       = (state == REQ);
  assign insn_pc          = head[EW-1:DATA_WIDTH];
  assign insn             = head[DATA_WIDTH-1:0];

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    word_cnt_nx = word_cnt;
    discard_nx  = discard;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && !mem_busy && count <= CW'(FIFO_DEPTH - N)) state_nx = REQ;
      end
      REQ: begin
        // The strobe is already on the bus; a redirect here just poisons the burst.
        state_nx    = BURST;
        word_cnt_nx = '0;
        discard_nx  = redirect;
      end
      BURST: begin
        if (mem_busy) begin
          push = !discard && !redirect;
          if (word_cnt == 4'(N - 1)) begin
            state_nx   = IDLE;
            discard_nx = 1'b0;
            if (!discard && !redirect) fetch_pc_nx = fetch_pc + ADDR_WIDTH'(WORD_BYTES * N);
          end else begin
            word_cnt_nx = word_cnt + 4'd1;
            if (redirect) discard_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (redirect) fetch_pc_nx = redirect_aligned;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= PC_RESET;
      word_cnt <= '0;
      discard  <= 1'b0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      word_cnt <= word_cnt_nx;
      discard  <= discard_nx;
    end
  end

  insn_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_data  ({word_pc, mem_data}),
    .head       (head),
    .head_valid (insn_valid),
    .count      (count)
  );

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (push)        stat_words  <= stat_words + 32'd1;
      if (!insn_valid) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: burst memory responder, queue-based
// reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] PC0 = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_data = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] insn, insn_pc;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_words, stat_stalls;
`endif

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .PC_RESET   (PC0),
    .BURST_CODE (2'b01),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_access_size (mem_access_size),
    .mem_rw          (mem_rw),
    .mem_enable      (mem_enable),
    .mem_busy        (mem_busy),
    .mem_data        (mem_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .insn            (insn),
    .insn_pc         (insn_pc),
    .insn_valid      (insn_valid),
    .insn_ready      (insn_ready)
`ifdef FETCH_STATS_EN
    ,
    .stat_words      (stat_words),
    .stat_stalls     (stat_stalls)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  logic [31:0] en_addr[$];
  logic [31:0] exp_pc = PC0;
  logic [31:0] last_insn = 32'd0, last_pc = 32'd0, base = 32'd0;
  bit          outstanding = 0, disc = 0, exp_en = 0, armed = 0, nxt_en;
  int          words = 0, sz;
  int unsigned m_words = 0, m_stalls = 0;

  // memory responder state
  bit          pend = 0;
  logic [31:0] pend_addr = 32'd0, maddr = 32'd0;
  int          remaining = 0, waitc = 0, mem_wait = 0;

  always @(negedge clock) begin
    entry_t e;
    if (armed) begin
      check("insn_valid", 32'(insn_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("insn", insn, q[0].data);
        check("insn_pc", insn_pc, q[0].pc);
        last_insn = q[0].data;
        last_pc   = q[0].pc;
      end else begin
        check("insn_hold", insn, last_insn);
        check("insn_pc_hold", insn_pc, last_pc);
      end
      check("mem_enable", 32'(mem_enable), 32'(exp_en));
      if (mem_enable) begin
        check("mem_address", mem_address, exp_pc);
        check("mem_size", 32'(mem_access_size), 32'd1);
        check("mem_rw", 32'(mem_rw), 32'd0);
        en_addr.push_back(mem_address);
      end
`ifdef FETCH_STATS_EN
      check("stat_words", stat_words, m_words);
      check("stat_stalls", stat_stalls, m_stalls);
`endif
    end
    if (mem_enable === 1'b1) begin
      pend      = 1;
      pend_addr = mem_address;
    end
    // advance the model by the edge about to happen
    sz     = q.size();
    nxt_en = !reset && !mem_enable && !outstanding && !mem_busy && !redirect && (sz <= DEPTH - N);
    if (reset) begin
      q.delete();
      exp_pc      = PC0;
      outstanding = 0;
      disc        = 0;
      m_words     = 0;
      m_stalls    = 0;
      last_insn   = 32'd0;
      last_pc     = 32'd0;
      armed       = 1;
    end else begin
      if (sz == 0) m_stalls++;
      if (insn_ready && sz > 0) void'(q.pop_front());
      if (mem_enable) begin
        outstanding = 1;
        words       = 0;
        base        = exp_pc;
        disc        = redirect;
      end else if (outstanding && mem_busy) begin
        if (!disc && !redirect) begin
          e.pc   = base + 32'(4 * words);
          e.data = mem_data;
          q.push_back(e);
          m_words++;
        end
        words++;
        if (words == N) begin
          outstanding = 0;
          if (!disc && !redirect) exp_pc = base + 32'(4 * N);
        end else if (redirect) begin
          disc = 1;
        end
      end
      if (redirect) begin
        q.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end
    end
    exp_en = nxt_en;
  end

  // Memory: after an accepted strobe, mem_wait idle cycles then N busy words (data = ~address).
  always @(posedge clock) begin
    #1;
    if (pend) begin
      pend      = 0;
      remaining = N;
      waitc     = mem_wait;
      maddr     = pend_addr;
    end
    if (remaining > 0 && waitc > 0) begin
      mem_busy = 1'b0;
      waitc--;
    end else if (remaining > 0) begin
      mem_busy = 1'b1;
      mem_data = ~maddr;
      maddr    = maddr + 32'd4;
      remaining--;
    end else begin
      mem_busy = 1'b0;
      mem_data = 32'd0;
    end
  end

  // ---------------- directed sequence ----------------
  logic [31:0] cap_pc[4];
  logic [31:0] cap_d0;
  int          cap_n;

  task automatic step_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_en(input string name, output logic [31:0] a);
    bit got = 0;
    a = 32'd0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (mem_enable === 1'b1) begin
        got = 1;
        a   = mem_address;
      end
    end
    if (!got) check(name, 32'd0, 32'd1);
  endtask

  task automatic collect4(input string name);
    cap_n = 0;
    for (int i = 0; i < 80 && cap_n < 4; i++) begin
      @(negedge clock);
      if (insn_valid && insn_ready) begin
        if (cap_n == 0) cap_d0 = insn;
        cap_pc[cap_n] = insn_pc;
        cap_n++;
      end
    end
    check(name, 32'(cap_n), 32'd4);
  endtask

  initial begin
    logic [31:0] a;
    int cnt;
    repeat (3) step_cycle();
    @(negedge clock);
    check("rst_valid", 32'(insn_valid), 32'd0);
    check("rst_insn", insn, 32'd0);
    check("rst_insn_pc", insn_pc, 32'd0);
    check("rst_address", mem_address, PC0);
    check("rst_enable", 32'(mem_enable), 32'd0);

    // streaming fetch from reset PC
    step_cycle();
    reset      = 1'b0;
    insn_ready = 1'b1;
    wait_en("t1_en_timeout", a);
    check("t1_addr", a, 32'h8002_0000);
    collect4("t1_count");
    check("t1_insn0", cap_d0, 32'h7FFD_FFFF);
    check("t1_pc0", cap_pc[0], 32'h8002_0000);
    check("t1_pc1", cap_pc[1], 32'h8002_0004);
    check("t1_pc2", cap_pc[2], 32'h8002_0008);
    check("t1_pc3", cap_pc[3], 32'h8002_000C);
    repeat (3) @(negedge clock);
    check("t1_second_req", (en_addr.size() >= 2) ? en_addr[1] : 32'd0, 32'h8002_0010);

    // backpressure: flush, then two bursts fill the FIFO
    step_cycle();
    insn_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h8003_0000;
    mem_wait    = 2;
    step_cycle();
    redirect = 1'b0;
    repeat (40) @(negedge clock);
    check("t2_occupancy", 32'(q.size()), 32'd8);
    check("t2_head_pc", insn_pc, 32'h8003_0000);
    check("t2_last_req", en_addr[en_addr.size() - 1], 32'h8003_0010);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_enable) cnt++;
    end
    check("t2_no_third_req", 32'(cnt), 32'd0);
    step_cycle();
    insn_ready = 1'b1;
    mem_wait   = 0;
    wait_en("t2_en_timeout", a);
    check("t2_resume_addr", a, 32'h8003_0020);

    // redirect on the 2nd word of that burst
    step_cycle();
    step_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h8004_0002;
    step_cycle();
    redirect = 1'b0;
    @(negedge clock);
    check("t3_flush", 32'(insn_valid), 32'd0);
    check("t3_busy_still", 32'(mem_busy), 32'd1);
    wait_en("t3_en_timeout", a);
    check("t3_addr", a, 32'h8004_0000);

    // redirect coinciding with a pop and a pushed word, to a wrapping PC
    step_cycle();
    step_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clock);
    check("t4_valid_before", 32'(insn_valid), 32'd1);
    check("t4_busy_before", 32'(mem_busy), 32'd1);
    step_cycle();
    redirect = 1'b0;
    @(negedge clock);
    check("t4_flush", 32'(insn_valid), 32'd0);
    collect4("t5_count");
    check("t5_insn0", cap_d0, 32'h0000_0007);
    check("t5_pc0", cap_pc[0], 32'hFFFF_FFF8);
    check("t5_pc1", cap_pc[1], 32'hFFFF_FFFC);
    check("t5_pc2", cap_pc[2], 32'h0000_0000);
    check("t5_pc3", cap_pc[3], 32'h0000_0004);

    // reset in the middle of a burst; memory keeps busy for the remaining words
    wait_en("t6_en_timeout", a);
    step_cycle();
    step_cycle();
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("t6_empty", 32'(insn_valid), 32'd0);
    check("t6_busy_high", 32'(mem_busy), 32'd1);
`ifdef FETCH_STATS_EN
    check("t6_stat_words", stat_words, 32'd0);
`endif
    cnt = (mem_enable === 1'b1) ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (mem_enable) cnt++;
    end
    check("t6_no_req_while_busy", 32'(cnt), 32'd0);
    wait_en("t6_en2_timeout", a);
    check("t6_addr", a, 32'h8002_0000);
    repeat (10) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
